// File: rtl/fir_accumulator.sv
// ---------------------------------------------------------------------------
// fir_accumulator
//   Sums N_TAPS signed products from the FIR tap multiplier into one output
//   sample. Drives tap_idx so the delay-line mux and coefficient memory feed
//   products in tap order. The result is held on a valid/ready handshake as
//   both the full-width sum and a Q15-scaled, saturated 16-bit sample.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           begin a sample (taken in IDLE, or in DONE with out_ready)
//   mnozenie_wynik  signed product for tap tap_idx
//   mnozenie_valid  product valid this cycle
//   tap_idx         tap currently being accumulated
//   busy            high while accumulating or holding a result
//   acc_out         signed full-precision sum (registered)
//   wynik_out       sat16(acc >>> SHIFT) (registered)
//   out_valid       acc_out / wynik_out valid
//   out_ready       consumer accepts the result
// ---------------------------------------------------------------------------
module fir_accumulator #(
    parameter int N_TAPS = 16,
    parameter int IN_W   = 32,
    parameter int ACC_W  = 40,
    parameter int SHIFT  = 15,
    localparam int TAP_W = $clog2(N_TAPS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [IN_W-1:0]         mnozenie_wynik,
    input  logic                    mnozenie_valid,
    output logic [TAP_W-1:0]        tap_idx,
    output logic                    busy,
    output logic [ACC_W-1:0]        acc_out,
    output logic [15:0]             wynik_out,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);
    localparam logic [TAP_W-1:0]        LAST_TAP = TAP_W'(N_TAPS - 1);

    logic [1:0]              state;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum_next;
    logic signed [ACC_W-1:0] shifted;
    logic [15:0]             sat16;

    // Running sum including the product presented this cycle; on the last
    // tap this is the final sample, registered straight into the outputs.
    assign sum_next = acc + $signed({{(ACC_W-IN_W){mnozenie_wynik[IN_W-1]}}, mnozenie_wynik});
    assign shifted  = sum_next >>> SHIFT;

    always_comb begin
        sat16 = shifted[15:0];
        if (shifted > SAT_MAX)
            sat16 = 16'h7fff;
        else if (shifted < SAT_MIN)
            sat16 = 16'h8000;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            tap_idx   <= '0;
            acc_out   <= '0;
            wynik_out <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tap_idx <= '0;
                    if (start) begin
                        state <= ACC;
                        acc   <= '0;
                    end
                end
                ACC: begin
                    // Gaps (valid low) simply hold acc and tap_idx.
                    if (mnozenie_valid) begin
                        acc <= sum_next;
                        if (tap_idx == LAST_TAP) begin
                            acc_out   <= sum_next;
                            wynik_out <= sat16;
                            out_valid <= 1'b1;
                            tap_idx   <= '0;
                            state     <= DONE;
                        end else begin
                            tap_idx <= tap_idx + TAP_W'(1);
                        end
                    end
                end
                DONE: begin
                    // Result is held until accepted; start with the accept
                    // chains directly into the next sample.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (start) begin
                            state <= ACC;
                            acc   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_accumulator.sv
module tb_fir_accumulator;

    localparam int N_TAPS = 4;
    localparam int IN_W   = 32;
    localparam int ACC_W  = 40;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [IN_W-1:0]   mnozenie_wynik;
    logic              mnozenie_valid;
    logic [1:0]        tap_idx;
    logic              busy;
    logic [ACC_W-1:0]  acc_out;
    logic [15:0]       wynik_out;
    logic              out_valid;
    logic              out_ready;

    int checks = 0;
    int errors = 0;

    fir_accumulator #(.N_TAPS(N_TAPS), .IN_W(IN_W), .ACC_W(ACC_W), .SHIFT(15)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .mnozenie_wynik(mnozenie_wynik),
        .mnozenie_valid(mnozenie_valid),
        .tap_idx(tap_idx),
        .busy(busy),
        .acc_out(acc_out),
        .wynik_out(wynik_out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_sample();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    // Feeds N_TAPS products with 'gap' idle cycles before each beat.
    task automatic feed(input logic [31:0] p0, input logic [31:0] p1,
                        input logic [31:0] p2, input logic [31:0] p3, input int gap);
        logic [31:0] p [4];
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap; g++) begin
                mnozenie_valid = 1'b0;
                mnozenie_wynik = 32'hdeadbeef;
                step();
                chk("tap_idx_gap", 64'(tap_idx), 64'(i));
            end
            chk("tap_idx_beat", 64'(tap_idx), 64'(i));
            chk("no_valid_mid", 64'(out_valid), 64'd0);
            mnozenie_valid = 1'b1;
            mnozenie_wynik = p[i];
            step();
        end
        mnozenie_valid = 1'b0;
    endtask

    task automatic finish(input logic [ACC_W-1:0] exp_acc, input logic [15:0] exp_w);
        chk("out_valid", 64'(out_valid), 64'd1);
        chk("acc_out", 64'(acc_out), 64'(exp_acc));
        chk("wynik_out", 64'(wynik_out), 64'(exp_w));
        chk("tap_idx_done", 64'(tap_idx), 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("out_valid_clr", 64'(out_valid), 64'd0);
        chk("busy_clr", 64'(busy), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mnozenie_wynik = '0; mnozenie_valid = 1'b0; out_ready = 1'b0;
        #2;
        chk("rst_acc", 64'(acc_out), 64'd0);
        chk("rst_wynik", 64'(wynik_out), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tap", 64'(tap_idx), 64'd0);
        step();
        rst = 1'b0;
        step();

        // Idle ignores valid beats
        mnozenie_valid = 1'b1; mnozenie_wynik = 32'd5;
        step();
        mnozenie_valid = 1'b0;
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_tap", 64'(tap_idx), 64'd0);

        // Basic sum: 15 + 2000 + 60000 - 1 = 62014, >>>15 = 1
        start_sample();
        feed(32'd15, 32'd2000, 32'd60000, 32'hffffffff, 0);
        finish(40'd62014, 16'd1);

        // Positive saturation: 4 * 2^30 = 2^32
        start_sample();
        feed(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000, 0);
        finish(40'h0100000000, 16'h7fff);

        // Negative saturation: -2^32
        start_sample();
        feed(32'hc0000000, 32'hc0000000, 32'hc0000000, 32'hc0000000, 0);
        finish(40'hff00000000, 16'h8000);

        // Floor on negative: -1 >>> 15 = -1
        start_sample();
        feed(32'hffffffff, 32'd0, 32'd0, 32'd0, 0);
        finish(40'hffffffffff, 16'hffff);

        // Gaps: 32768*(1+2+3+4) = 327680 -> 10
        start_sample();
        feed(32'd32768, 32'd65536, 32'd98304, 32'd131072, 3);
        finish(40'd327680, 16'd10);

        // Backpressure: 100+200+300+400 = 1000 held in DONE
        start_sample();
        feed(32'd100, 32'd200, 32'd300, 32'd400, 0);
        for (int c = 0; c < 5; c++) begin
            mnozenie_valid = 1'b1;
            mnozenie_wynik = 32'h12345678;
            start = c[0];
            step();
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_acc", 64'(acc_out), 64'd1000);
            chk("bp_wynik", 64'(wynik_out), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
        end
        mnozenie_valid = 1'b0;
        out_ready = 1'b1; start = 1'b1;
        step();
        out_ready = 1'b0; start = 1'b0;
        chk("b2b_busy", 64'(busy), 64'd1);
        chk("b2b_valid", 64'(out_valid), 64'd0);
        chk("b2b_acc_held", 64'(acc_out), 64'd1000);
        // Next sample must start from zero: 1+2+3+4 = 10
        feed(32'd1, 32'd2, 32'd3, 32'd4, 0);
        finish(40'd10, 16'd0);

        // Reset mid-accumulation discards the partial sum
        start_sample();
        mnozenie_valid = 1'b1; mnozenie_wynik = 32'd32768;
        step();
        step();
        chk("mid_tap", 64'(tap_idx), 64'd2);
        mnozenie_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_tap", 64'(tap_idx), 64'd0);
        chk("arst_acc", 64'(acc_out), 64'd0);
        chk("arst_wynik", 64'(wynik_out), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        step();
        rst = 1'b0;
        step();
        start_sample();
        feed(32'd32768, 32'd32768, 32'd32768, 32'd32768, 0);
        finish(40'd131072, 16'd4);

        // start held during ACC is ignored: 10+20+30+40 = 100
        start_sample();
        start = 1'b1;
        feed(32'd10, 32'd20, 32'd30, 32'd40, 1);
        start = 1'b0;
        finish(40'd100, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
